// File: rtl/deserializer_framed_if.sv
// Handshake/bus bundle for deserializer_framed: serial beat input side and
// valid/ready parallel word output side.
interface deserializer_framed_if #(
    parameter int N     = 8,
    parameter int LANES = 1
);
    logic             i_enable;
    logic [LANES-1:0] i_data;
    logic             i_sof;
    logic             i_ready;
    logic             o_valid;
    logic [N-1:0]     o_data;
    logic             o_overrun;
    logic             o_busy;

    modport slave (
        input  i_enable, i_data, i_sof, i_ready,
        output o_valid, o_data, o_overrun, o_busy
    );

    modport master (
        output i_enable, i_data, i_sof, i_ready,
        input  o_valid, o_data, o_overrun, o_busy
    );
endinterface

// File: rtl/deserializer_framed.sv
// Multi-lane serial-to-parallel converter with start-of-frame realignment and
// a single-entry valid/ready output register that flags dropped words.
module deserializer_framed #(
    parameter int N         = 8,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    deserializer_framed_if.slave bus
);
    localparam int BEATS = N / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [N-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  data_q, data_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  base;
    logic [N-1:0]  shifted;
    logic [CW-1:0] beat_idx;
    logic          complete;
    logic          slot_free;

    always_comb begin
        // A start-of-frame beat restarts the word from an empty register.
        base     = bus.i_sof ? '0 : shift_q;
        beat_idx = bus.i_sof ? '0 : cnt_q;
        if (MSB_FIRST)
            shifted = (base << LANES) | N'(bus.i_data);
        else
            shifted = (base >> LANES) | (N'(bus.i_data) << (N - LANES));

        complete  = bus.i_enable && (beat_idx == LAST_BEAT);
        slot_free = !valid_q || bus.i_ready;

        shift_d   = shift_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q && !bus.i_ready;
        data_d    = data_q;
        overrun_d = 1'b0;

        if (bus.i_enable) begin
            shift_d = shifted;
            cnt_d   = complete ? '0 : CW'(beat_idx + 1'b1);
        end

        // The completed word bypasses the shift register so it is ready one edge after the last beat.
        if (complete) begin
            if (slot_free) begin
                valid_d = 1'b1;
                data_d  = shifted;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_data    = data_q;
    assign bus.o_overrun = overrun_q;
    assign bus.o_busy    = busy_q;
endmodule

// File: doc/deserializer_framed.md
Name: deserializer_framed

Overview:
- Parametrised multi-lane serial-to-parallel converter for front-end sample capture.
- Shifts LANES bits per enabled cycle into an N-bit word.
- Supports selectable bit order and start-of-frame realignment.
- Outputs each word through a single-entry valid/ready holding register with overrun signalling.
- Sits between the serial input pins/sync logic and the parallel datapath, e.g. the filter/LMS core.

Parameters:
- N, 8, output word width in bits; must be at least 2.
- LANES, 1, bits accepted per enabled cycle; N must be divisible by LANES.
- MSB_FIRST, 1, 1 = first received beat lands in the most-significant bits; 0 = first beat lands in the least-significant bits.

Ports:
- i_clock  in  1  single clock; all logic rising-edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_enable  in  1  i_data is sampled this cycle (one beat).
- i_data  in  LANES  serial beat; bit LANES-1 is the most significant bit within the beat.
- i_sof  in  1  start of frame; qualified by i_enable.
- i_ready  in  1  downstream accepts o_data when o_valid is 1.
- o_valid  out  1  o_data holds an unconsumed word.
- o_data  out  N  assembled word.
- o_overrun  out  1  one-cycle pulse: a completed word was dropped.
- o_busy  out  1  partial word in progress (beat counter is nonzero).

Behaviour:
- Reset: synchronous, active-high; takes priority over everything. The shift register, beat counter, o_valid, o_data, o_overrun and o_busy all clear to 0. Reset mid-word discards the partial word; a held unconsumed word is also lost.
- BEATS = N/LANES. Beat counter width is clog2(BEATS), minimum 1 bit. The counter runs 0..BEATS-1 and wraps to 0 after the last beat.
- i_enable = 0: no state change except the handshake (o_valid clears if i_ready). i_sof is ignored.
- i_enable = 1:
  - The beat is appended to the shift register.
  - MSB_FIRST = 1: shift left by LANES and insert i_data at the bottom.
  - MSB_FIRST = 0: shift right by LANES and insert i_data at the top.
  - Result: in the completed word, beat k occupies o_data[N-1-k*LANES -: LANES] when MSB_FIRST = 1, and o_data[k*LANES +: LANES] when MSB_FIRST = 0.
- i_sof with i_enable = 1:
  - Discards any partial word; no o_overrun.
  - The current beat is treated as beat 0 and the counter becomes 1.
  - When BEATS = 1, the beat completes a word immediately.
- Word completion is the cycle in which the beat with counter = BEATS-1 is sampled. The completed word includes the current beat; it is a bypass of the shift register, so no extra beat is needed.
- Output slot is free if o_valid = 0, or if o_valid = 1 and i_ready = 1 in the same cycle. Same-cycle consume and load is allowed, so back-to-back words with no gap work at i_ready = 1.
- Completion with a free slot: o_data loads on the next edge and o_valid = 1. Latency is 1 cycle from the final beat.
- Completion with the slot full (o_valid = 1, i_ready = 0):
  - The new word is dropped; o_data and o_valid are unchanged.
  - o_overrun = 1 for exactly one cycle, on the next edge.
  - The beat counter still wraps to 0.
- o_valid stays 1 and o_data stays stable until accepted (o_valid and i_ready both 1 at an edge). o_valid then clears unless a new word loads in the same cycle.
- o_data holds its last value after o_valid clears.
- o_busy = (beat counter != 0), registered.

Test Plan:
- N=8, LANES=1, MSB_FIRST=1, i_ready=1: bits 1,1,0,0,0,0,0,0 on consecutive enabled cycles -> o_valid for 1 cycle, o_data=0xC0, one cycle after the 8th bit. Same bits with MSB_FIRST=0 -> o_data=0x03.
- N=8, LANES=2, MSB_FIRST=1: beats 2'b11, 2'b00, 2'b10, 2'b01 -> o_data=0xC9; o_busy=1 after beats 1-3, 0 after beat 4.
- Gapped enable: the same 8 bits with i_enable low on alternate cycles -> o_data=0xC0; no intermediate o_valid.
- Backpressure, N=8, LANES=1, i_ready=0: send word 0x12 then 0x34 -> o_data stays 0x12, o_valid stays 1, o_overrun pulses once after the 8th bit of 0x34. Then raise i_ready -> 0x12 is consumed and o_valid drops. A third word 0x56 is delivered normally.
- Realignment: send 3 bits of 1, then i_sof with bits 0,1,0,1,0,1,0,1 -> o_data=0x55; no o_overrun; the 3 stray bits have no effect.
- Reset mid-operation: after 5 bits with a held word present, pulse i_reset for 1 cycle -> the next cycle shows o_valid=0, o_busy=0, o_data=0. The next 8 bits 1,0,1,0,0,1,0,1 produce o_data=0xA5.
